// File: rtl/ita_scan_rx_if.sv
// ita_scan_rx_if
// Bundles the scan bus (digit select + segment pattern) driven by the display
// scanner together with the committed-frame read port and the status outputs
// of the scan receiver.
//   sel         [11:0]  one-hot digit select, bit k = digit k
//   segm        [13:0]  segment pattern for the selected digit
//   rd_addr     [3:0]   digit index to read from the committed frame
//   rd_char     [5:0]   character code at rd_addr (combinational)
//   frame_valid         one-cycle pulse on frame commit
//   frame_bad           committed frame holds at least one unknown glyph
//   err_seq             one-cycle pulse on scan-order / select error
//   frame_cnt   [7:0]   committed frame count (wraps)
// master: scanner / host side.  slave: the receiver.
interface ita_scan_rx_if;
    logic [11:0] sel;
    logic [13:0] segm;
    logic [3:0]  rd_addr;
    logic [5:0]  rd_char;
    logic        frame_valid;
    logic        frame_bad;
    logic        err_seq;
    logic [7:0]  frame_cnt;

    modport master (
        output sel,
        output segm,
        output rd_addr,
        input  rd_char,
        input  frame_valid,
        input  frame_bad,
        input  err_seq,
        input  frame_cnt
    );

    modport slave (
        input  sel,
        input  segm,
        input  rd_addr,
        output rd_char,
        output frame_valid,
        output frame_bad,
        output err_seq,
        output frame_cnt
    );
endinterface

// File: rtl/ita_scan_rx.sv
// ita_scan_rx
// Receiving end of the 12-digit, 14-segment multiplexed display scan bus.
// Each rising edge samples the digit select and segment pattern, decodes the
// pattern to a 6-bit character code and assembles 12-digit frames in a shadow
// buffer. A frame that arrives in strict order 0..11 (blank cycles allowed in
// between) is copied to the committed buffer, which feeds the combinational
// read port. Out-of-order or malformed selects abandon the partial frame.
// Ports:
//   vdd, vss   supply pins (only with USE_POWER_PINS)
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        ita_scan_rx_if.slave (scan inputs, read port, status outputs)
module ita_scan_rx (
`ifdef USE_POWER_PINS
    inout wire vdd,
    inout wire vss,
`endif
    input  logic              clk,
    input  logic              rst_n,
    ita_scan_rx_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_DIGIT = 4'd11;
    localparam logic [5:0] CODE_UNK   = 6'h3F;

    // Segment pattern to character code; anything unrecognised maps to 0x3F.
    function automatic logic [5:0] glyph_decode(input logic [13:0] pat);
        logic [5:0] code;
        case (pat)
            14'h0000: code = 6'h00;
            14'h3BC0: code = 6'h01;
            14'h2412: code = 6'h02;
            14'h1B28: code = 6'h03;
            14'h33C4: code = 6'h04;
            default:  code = CODE_UNK;
        endcase
        return code;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  exp_r;
    logic [3:0]  exp_nxt_s;
    logic [5:0]  shadow_r [12];
    logic [5:0]  commit_r [12];
    logic        unk_acc_r;
    logic        unk_nxt_s;
    logic        frame_valid_r;
    logic        frame_bad_r;
    logic        err_seq_r;
    logic [7:0]  frame_cnt_r;

    logic        blank_s;
    logic        one_hot_s;
    logic [3:0]  idx_s;
    logic [5:0]  code_s;
    logic        unk_s;
    logic        wr_en_s;
    logic        commit_s;
    logic        err_s;
    logic [5:0]  rd_char_s;

    // Classify the sampled select and decode the sampled pattern.
    always_comb begin
        blank_s   = (bus.sel == 12'd0);
        // x & (x-1) clears the lowest set bit, so zero there means one bit set
        one_hot_s = !blank_s && ((bus.sel & (bus.sel - 12'd1)) == 12'd0);
        // OR-encode; only meaningful when one_hot_s is true
        idx_s     = 4'd0;
        for (int i = 0; i < 12; i++) begin
            idx_s = idx_s | (bus.sel[i] ? 4'(i) : 4'd0);
        end
        code_s    = glyph_decode(bus.segm);
        unk_s     = (code_s == CODE_UNK);
    end

    // Scan-order state machine: next state, expected digit, write/commit/error strobes.
    always_comb begin
        state_nxt_s = state_r;
        exp_nxt_s   = exp_r;
        wr_en_s     = 1'b0;
        commit_s    = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_HUNT: begin
                // only a digit-0 select can open a frame; everything else is ignored silently
                if (one_hot_s && (idx_s == 4'd0)) begin
                    wr_en_s     = 1'b1;
                    exp_nxt_s   = 4'd1;
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end
            ST_CAPTURE: begin
                if (blank_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else if (!one_hot_s) begin
                    err_s       = 1'b1;
                    exp_nxt_s   = 4'd0;
                    state_nxt_s = ST_HUNT;
                end else if (idx_s == exp_r) begin
                    wr_en_s = 1'b1;
                    if (idx_s == LAST_DIGIT) begin
                        // stay in CAPTURE expecting digit 0 so frames can run back to back
                        commit_s  = 1'b1;
                        exp_nxt_s = 4'd0;
                    end else begin
                        exp_nxt_s = exp_r + 4'd1;
                    end
                end else if (idx_s == 4'd0) begin
                    // early digit 0: the scanner restarted, resync on this digit
                    err_s     = 1'b1;
                    wr_en_s   = 1'b1;
                    exp_nxt_s = 4'd1;
                end else begin
                    err_s       = 1'b1;
                    exp_nxt_s   = 4'd0;
                    state_nxt_s = ST_HUNT;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
                exp_nxt_s   = 4'd0;
            end
        endcase
    end

    // Unknown-glyph flag for the frame in progress; a digit-0 write starts a fresh frame.
    always_comb begin
        unk_nxt_s = unk_acc_r;
        if (wr_en_s) begin
            if (idx_s == 4'd0) begin
                unk_nxt_s = unk_s;
            end else begin
                unk_nxt_s = unk_acc_r | unk_s;
            end
        end else begin
            unk_nxt_s = unk_acc_r;
        end
    end

    // State, expected index and accumulated unknown flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_HUNT;
            exp_r     <= 4'd0;
            unk_acc_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            exp_r     <= exp_nxt_s;
            unk_acc_r <= unk_nxt_s;
        end
    end

    // Shadow buffer: captures each in-order digit as it arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++) begin
                shadow_r[i] <= 6'h00;
            end
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (wr_en_s && (idx_s == 4'(i))) begin
                    shadow_r[i] <= code_s;
                end
            end
        end
    end

    // Committed buffer, bad flag and frame counter; change only when digit 11 closes a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++) begin
                commit_r[i] <= 6'h00;
            end
            frame_bad_r <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else if (commit_s) begin
            // digit 11 is being sampled now, so take it straight from the decoder
            for (int i = 0; i < 11; i++) begin
                commit_r[i] <= shadow_r[i];
            end
            commit_r[11] <= code_s;
            frame_bad_r  <= unk_nxt_s;
            frame_cnt_r  <= frame_cnt_r + 8'd1;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid_r <= 1'b0;
            err_seq_r     <= 1'b0;
        end else begin
            frame_valid_r <= commit_s;
            err_seq_r     <= err_s;
        end
    end

    // Read port: mux the committed buffer; addresses 12..15 read as zero.
    always_comb begin
        rd_char_s = 6'h00;
        for (int i = 0; i < 12; i++) begin
            rd_char_s = rd_char_s | ((bus.rd_addr == 4'(i)) ? commit_r[i] : 6'h00);
        end
    end

    assign bus.rd_char     = rd_char_s;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_bad   = frame_bad_r;
    assign bus.err_seq     = err_seq_r;
    assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_ita_scan_rx.sv
`timescale 1ns/1ps
module tb_ita_scan_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ita_scan_rx_if bus();

`ifdef USE_POWER_PINS
    wire vdd;
    wire vss;
    ita_scan_rx dut (.vdd(vdd), .vss(vss), .clk(clk), .rst_n(rst_n), .bus(bus));
`else
    ita_scan_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #20 clk = ~clk;

    // glyph table: position in the table is the character code
    localparam logic [13:0] GLYPHS [5] = '{14'h0000, 14'h3BC0, 14'h2412, 14'h1B28, 14'h33C4};
    localparam logic [13:0] G_SP = 14'h0000;
    localparam logic [13:0] G_A  = 14'h3BC0;
    localparam logic [13:0] G_I  = 14'h2412;
    localparam logic [13:0] G_M  = 14'h1B28;
    localparam logic [13:0] G_R  = 14'h33C4;

    typedef struct {
        int         tag;
        logic [5:0] ch [12];
        bit         bad;
        int         cnt;
    } frame_t;

    frame_t     exp_frames[$];
    int         exp_errs[$];
    bit         m_cap;
    logic [5:0] m_part[$];
    int         m_cnt;
    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    logic [5:0] mon_last [12];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    function automatic logic [5:0] ref_code(input logic [13:0] p);
        for (int i = 0; i < 5; i++) begin
            if (p == GLYPHS[i]) return 6'(i);
        end
        return 6'h3F;
    endfunction

    // Reference model: a frame is the list of digits received so far in order.
    task automatic model_step(input logic [11:0] s, input logic [13:0] p);
        int         tag;
        int         k;
        logic [5:0] c;
        frame_t     f;
        tag = edge_cnt + 1;
        c   = ref_code(p);
        k   = 0;
        if (s == 12'd0) return;
        if ($countones(s) != 1) begin
            if (m_cap) exp_errs.push_back(tag);
            m_cap = 1'b0;
            m_part.delete();
            return;
        end
        for (int i = 0; i < 12; i++) if (s[i]) k = i;
        if (!m_cap) begin
            if (k == 0) begin
                m_cap = 1'b1;
                m_part.delete();
                m_part.push_back(c);
            end
        end else if (k == m_part.size()) begin
            m_part.push_back(c);
            if (m_part.size() == 12) begin
                f.tag = tag;
                f.bad = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    f.ch[i] = m_part[i];
                    if (m_part[i] == 6'h3F) f.bad = 1'b1;
                end
                m_cnt = (m_cnt + 1) % 256;
                f.cnt = m_cnt;
                exp_frames.push_back(f);
                m_part.delete();
            end
        end else if (k == 0) begin
            exp_errs.push_back(tag);
            m_part.delete();
            m_part.push_back(c);
        end else begin
            exp_errs.push_back(tag);
            m_cap = 1'b0;
            m_part.delete();
        end
    endtask

    task automatic drive(input logic [11:0] s, input logic [13:0] p);
        bus.sel  = s;
        bus.segm = p;
        model_step(s, p);
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input int d, input logic [13:0] p);
        drive(12'(1) << d, p);
    endtask

    task automatic send_frame(input logic [13:0] g [12]);
        for (int d = 0; d < 12; d++) send_digit(d, g[d]);
    endtask

    task automatic model_reset();
        m_cap = 1'b0;
        m_part.delete();
        m_cnt = 0;
    endtask

    // Monitor: pops expected events whenever the DUT reports them (or should have).
    initial begin
        frame_t f;
        int     t;
        int     a;
        bus.rd_addr = 4'd0;
        for (int i = 0; i < 12; i++) mon_last[i] = 6'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 12; i++) mon_last[i] = 6'h00;
                continue;
            end
            if (bus.frame_valid) begin
                if (exp_frames.size() == 0) begin
                    chk("frame_valid_unexpected", int'(bus.frame_valid), 0);
                end else begin
                    f = exp_frames.pop_front();
                    chk("frame_valid_timing", edge_cnt, f.tag);
                    chk("frame_bad", int'(bus.frame_bad), int'(f.bad));
                    chk("frame_cnt", int'(bus.frame_cnt), f.cnt);
                    for (int i = 0; i < 12; i++) begin
                        bus.rd_addr = 4'(i);
                        #1;
                        chk($sformatf("rd_char[%0d]", i), int'(bus.rd_char), int'(f.ch[i]));
                    end
                    bus.rd_addr = 4'd13;
                    #1;
                    chk("rd_char_oob", int'(bus.rd_char), 0);
                    for (int i = 0; i < 12; i++) mon_last[i] = f.ch[i];
                end
            end else if (exp_frames.size() > 0 && exp_frames[0].tag <= edge_cnt) begin
                chk("frame_valid_missing", int'(bus.frame_valid), 1);
                void'(exp_frames.pop_front());
            end
            if (bus.err_seq) begin
                if (exp_errs.size() == 0) begin
                    chk("err_seq_unexpected", int'(bus.err_seq), 0);
                end else begin
                    t = exp_errs.pop_front();
                    chk("err_seq_timing", edge_cnt, t);
                end
            end else if (exp_errs.size() > 0 && exp_errs[0] <= edge_cnt) begin
                chk("err_seq_missing", int'(bus.err_seq), 1);
                void'(exp_errs.pop_front());
            end
            // committed contents must hold between commits
            a = $urandom_range(0, 15);
            bus.rd_addr = 4'(a);
            #1;
            chk("rd_char_hold", int'(bus.rd_char), (a < 12) ? int'(mon_last[a]) : 0);
        end
    end

    initial begin
        logic [13:0] fr  [12];
        logic [13:0] fr2 [12];
        logic [13:0] rf  [12];
        logic [11:0] s;
        logic [13:0] p;
        int          r;
        int          ei;

        fr = '{G_I, G_R, G_A, G_A, G_M, G_SP, G_SP, G_SP, G_SP, G_SP, G_SP, G_SP};
        bus.sel  = 12'd0;
        bus.segm = 14'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_frame_valid", int'(bus.frame_valid), 0);
        chk("reset_frame_bad", int'(bus.frame_bad), 0);
        chk("reset_err_seq", int'(bus.err_seq), 0);
        chk("reset_frame_cnt", int'(bus.frame_cnt), 0);
        chk("reset_rd_char", int'(bus.rd_char), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // two gap-free passes
        send_frame(fr);
        send_frame(fr);
        chk("frame_cnt_two", int'(bus.frame_cnt), 2);
        drive(12'd0, 14'd0);

        // unknown glyph at digit 5, then clean
        fr2 = fr;
        fr2[5] = 14'h3FFF;
        send_frame(fr2);
        chk("frame_bad_set", int'(bus.frame_bad), 1);
        send_frame(fr);
        chk("frame_bad_clear", int'(bus.frame_bad), 0);

        // skipped digit 3
        send_frame(fr);
        for (int d = 0; d < 3; d++) send_digit(d, G_A);
        drive(12'h010, G_M);
        drive(12'd0, 14'd0);
        send_frame(fr);

        // malformed select mid-frame
        for (int d = 0; d < 4; d++) send_digit(d, G_R);
        drive(12'h003, G_A);
        send_frame(fr);

        // early digit 0 mid-frame restarts capture
        for (int d = 0; d < 5; d++) send_digit(d, G_M);
        send_frame(fr2);

        // three blank cycles between digits 4 and 5
        for (int d = 0; d < 5; d++) send_digit(d, G_I);
        repeat (3) drive(12'd0, 14'(GLYPHS[$urandom_range(0, 4)]));
        for (int d = 5; d < 12; d++) send_digit(d, G_A);

        // randomized scan traffic
        repeat (2000) begin
            r  = $urandom_range(0, 99);
            ei = m_cap ? m_part.size() : 0;
            if (r < 72)      s = 12'(1) << ei;
            else if (r < 82) s = 12'd0;
            else if (r < 91) s = 12'(1) << $urandom_range(0, 11);
            else             s = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 99) < 88) p = GLYPHS[$urandom_range(0, 4)];
            else                            p = 14'($urandom_range(0, 16383));
            drive(s, p);
        end

        // run the counter up to 255 then wrap
        while (m_cnt != 255) begin
            for (int d = 0; d < 12; d++) rf[d] = GLYPHS[$urandom_range(0, 4)];
            send_frame(rf);
        end
        send_frame(fr2);
        chk("frame_cnt_wrap", int'(bus.frame_cnt), 0);
        send_frame(fr2);

        // reset in the middle of a frame
        for (int d = 0; d < 6; d++) send_digit(d, G_A);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("midrst_frame_valid", int'(bus.frame_valid), 0);
        chk("midrst_frame_bad", int'(bus.frame_bad), 0);
        chk("midrst_err_seq", int'(bus.err_seq), 0);
        chk("midrst_frame_cnt", int'(bus.frame_cnt), 0);
        chk("midrst_rd_char", int'(bus.rd_char), 0);
        bus.sel = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(fr);
        chk("post_reset_cnt", int'(bus.frame_cnt), 1);
        repeat (3) drive(12'd0, 14'd0);

        chk("pending_frames", exp_frames.size(), 0);
        chk("pending_errs", exp_errs.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ita_scan_rx.md
# ita_scan_rx

Receiving end of the 12-digit, 14-segment multiplexed display scan bus. It samples the one-hot digit select and segment pattern lines driven by the display scanner every clock, and decodes each segment pattern back into a 6-bit character code. It reassembles complete 12-digit frames in a buffer, checks scan ordering, and exposes the last good frame through a combinational read port. It sits on the user-area bus next to the display drivers, as an on-chip loopback and self-check monitor.

## Interface
- No parameters. Frame length is fixed at 12 digits, the segment width at 14, and the code width at 6.
- `vdd`  inout  1  supply; present only under `USE_POWER_PINS`.
- `vss`  inout  1  ground; present only under `USE_POWER_PINS`.
- `clk`  input  1  single clock; every register updates on its rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `sel`  input  12  scan digit select; bit k means digit k (k = 0..11).
- `segm`  input  14  segment pattern for the selected digit.
- `rd_addr`  input  4  digit index to read from the committed frame.
- `rd_char`  output  6  character code at `rd_addr`; combinational from the committed buffer; reads 0 when `rd_addr` > 11.
- `frame_valid`  output  1  one-cycle pulse when a frame is committed.
- `frame_bad`  output  1  set when the committed frame contains at least one unknown glyph; updated only at commit.
- `err_seq`  output  1  one-cycle pulse on a scan-order or select-encoding error.
- `frame_cnt`  output  8  count of committed frames; wraps 255 -> 0.

## Operation
- Glyph decode:
  - 0x0000 -> 0x00 (space)
  - 0x3BC0 -> 0x01 (A)
  - 0x2412 -> 0x02 (I)
  - 0x1B28 -> 0x03 (M)
  - 0x33C4 -> 0x04 (R)
  - any other pattern -> 0x3F (unknown)
- Buffers: a 12x6 shadow buffer fills during capture; a 12x6 committed buffer feeds `rd_char`. A shadow unknown-flag accumulates across the frame.
- Select classification, once per sampled cycle:
  - `sel` = 0: blank cycle. Ignored in every state; no state or index change.
  - exactly one bit set: digit index k.
  - two or more bits set: malformed.
- State HUNT:
  - Index 0: write the decoded code into shadow[0], clear the shadow unknown-flag and OR in this digit's unknown status, set expected index to 1, go to CAPTURE.
  - Any other index: ignored.
  - Malformed: ignored; no `err_seq` in HUNT.
- State CAPTURE, expected index e:
  - Index k = e: write shadow[k] and OR in the unknown status.
  - If k = 11 (commit): copy the shadow buffer to the committed buffer, `frame_bad` <= accumulated flag, pulse `frame_valid`, increment `frame_cnt`. Expected index becomes 0 and the state stays CAPTURE, so back-to-back frames are captured.
  - If k < 11: e <= e+1.
  - Index k = 0 with e != 0: pulse `err_seq`, discard the partial frame, restart capture at digit 0 (shadow[0] written, e <= 1).
  - Other k != e: pulse `err_seq`, discard the partial frame, go to HUNT.
  - Malformed: pulse `err_seq`, discard the partial frame, go to HUNT.
- A discarded partial frame never alters the committed buffer, `frame_bad` or `frame_cnt`.

## Timing
- Reset values:
  - State HUNT, expected index 0.
  - Both buffers all 0x00.
  - `frame_valid`, `frame_bad`, `err_seq` = 0; `frame_cnt` = 0.
  - `rd_char` therefore reads 0.
- Reset asserted mid-frame clears everything immediately, regardless of `clk`.
- `sel`/`segm` are sampled at each rising edge with no input pipeline.
- Latency: if digit 11 is sampled at edge T, `frame_valid`, the new `frame_bad`, the updated `frame_cnt` and the new committed contents are all visible after edge T.
  - `frame_valid` deasserts after edge T+1 unless another commit occurs at that edge.
- A gap-free scan (digit 0 through 11 on consecutive edges) gives `frame_valid` every 12 cycles. Each blank cycle adds one cycle of spacing.
- `err_seq` is high for exactly one cycle, the cycle after the offending sample.
- `rd_char` changes combinationally with `rd_addr`. It follows buffer contents from the cycle after commit.

## Test plan
- Reset, then drive the scanner pattern I,R,A,A,M,space x7 for two gap-free passes -> `frame_valid` pulses 12 cycles apart. `frame_cnt` = 2, `frame_bad` = 0, and `rd_char` for addresses 0..11 reads 02,04,01,01,03,00,00,00,00,00,00,00. `rd_addr` = 13 reads 00.
- One frame with `segm` = 0x3FFF at digit 5 -> `rd_char`[5] = 0x3F and `frame_bad` = 1. A following clean frame returns `frame_bad` to 0.
- Commit one good frame. Then send digits 0, 1, 2, then `sel` = 0x010 (skipping digit 3) -> `err_seq` is a single-cycle pulse, no `frame_valid`, the committed contents are unchanged, and the block resumes at the next `sel` = 0x001.
- Mid-frame, `sel` = 0x003 -> `err_seq` pulse and return to HUNT. Mid-frame, `sel` = 0x001 -> `err_seq` pulse, and a frame completes 11 cycles later.
- Insert 3 blank cycles (`sel` = 0) between digits 4 and 5 -> `frame_valid` arrives 15 cycles after digit 0, with no `err_seq`.
- Preload `frame_cnt` to 255 via frames, then commit one more -> `frame_cnt` = 0. Assert `rst_n` low mid-frame -> all outputs 0 immediately, and the next full frame commits normally.
